// File: rtl/load_pkg.sv
// Shared definitions for the load unit: load opcodes, FSM states and the
// opcode decoder that yields access size and signedness.
package load_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } ld_size_t;

    typedef struct packed {
        ld_size_t size;
        logic     sign;
    } ld_decode_t;

    // Any opcode outside the five defined loads behaves as a full-word load.
    function automatic ld_decode_t decode_op(input logic [2:0] op);
        ld_decode_t dec;
        dec.size = SZ_WORD;
        dec.sign = 1'b0;
        case (op)
            LD_LB: begin
                dec.size = SZ_BYTE;
                dec.sign = 1'b1;
            end
            LD_LH: begin
                dec.size = SZ_HALF;
                dec.sign = 1'b1;
            end
            LD_LBU: begin
                dec.size = SZ_BYTE;
                dec.sign = 1'b0;
            end
            LD_LHU: begin
                dec.size = SZ_HALF;
                dec.sign = 1'b0;
            end
            default: begin
                dec.size = SZ_WORD;
                dec.sign = 1'b0;
            end
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte/half/word lane selection with sign or zero extension.
// Halfword lane is chosen by addr_lo[1] only; addr_lo[0] never affects halves.
module load_extract
    import load_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    ld_decode_t  dec;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Pick the addressed lane out of the memory word and extend it to 32 bits.
    always_comb begin
        dec      = decode_op(op);
        byte_val = word[7:0];
        half_val = addr_lo[1] ? word[31:16] : word[15:0];
        data     = word;

        case (addr_lo)
            2'd0:    byte_val = word[7:0];
            2'd1:    byte_val = word[15:8];
            2'd2:    byte_val = word[23:16];
            default: byte_val = word[31:24];
        endcase

        case (dec.size)
            SZ_BYTE: data = {{24{dec.sign & byte_val[7]}}, byte_val};
            SZ_HALF: data = {{16{dec.sign & half_val[15]}}, half_val};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// MEM-stage load unit: word-aligned DRAM read over req/ack, lane extraction,
// result handed to WB over valid/ready. One load in flight at a time.
// Optional feature macro: LOAD_UNIT_MISALIGN_TRAP_EN -- when defined, a
// misaligned lh/lhu/lw skips the memory read and returns ld_err=1 directly.
module load_unit
    import load_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [2:0]  ld_op,
    input  logic [31:0] ld_addr,
    input  logic [4:0]  ld_rd,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        ld_err
);

    // Counter value seen in the last permitted REQ cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  lo_q;
    logic [7:0]  cnt;
    logic [31:0] ext_data;
    logic        misalign;

    load_extract u_extract (
        .op      (op_q),
        .addr_lo (lo_q),
        .word    (mem_rdata),
        .data    (ext_data)
    );

`ifdef LOAD_UNIT_MISALIGN_TRAP_EN
    ld_decode_t in_dec;

    // Flag halfword accesses on odd addresses and word accesses off a word boundary.
    always_comb begin
        in_dec   = decode_op(ld_op);
        misalign = 1'b0;
        if (in_dec.size == SZ_HALF && ld_addr[0])
            misalign = 1'b1;
        else if (in_dec.size == SZ_WORD && ld_addr[1:0] != 2'b00)
            misalign = 1'b1;
    end
`else
    assign misalign = 1'b0;
`endif

    // Main FSM; every interface output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= LD_LB;
            lo_q     <= 2'b00;
            cnt      <= 8'd0;
            ld_ready <= 1'b1;
            mem_req  <= 1'b0;
            mem_addr <= 32'd0;
            wb_valid <= 1'b0;
            wb_data  <= 32'd0;
            wb_rd    <= 5'd0;
            ld_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        op_q     <= ld_op;
                        lo_q     <= ld_addr[1:0];
                        wb_rd    <= ld_rd;
                        mem_addr <= {ld_addr[31:2], 2'b00};
                        ld_ready <= 1'b0;
                        if (misalign) begin
                            state    <= RESP;
                            wb_valid <= 1'b1;
                            wb_data  <= 32'd0;
                            ld_err   <= 1'b1;
                        end else begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                            cnt     <= 8'd0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_data  <= ext_data;
                        ld_err   <= 1'b0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_data  <= 32'd0;
                        ld_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (wb_ready) begin
                        state    <= IDLE;
                        wb_valid <= 1'b0;
                        ld_err   <= 1'b0;
                        ld_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ld_ready <= 1'b1;
                    mem_req  <= 1'b0;
                    wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Directed testbench for load_unit. Two instances share stimulus: dut uses the
// default timeout, dut_t uses TIMEOUT_CYC=4 for the timeout scenarios.
// Expectations follow LOAD_UNIT_MISALIGN_TRAP_EN when it is defined.
module tb_load_unit;
    import load_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic [2:0]  ld_op;
    logic [31:0] ld_addr;
    logic [4:0]  ld_rd;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_ready;

    logic        ld_ready, mem_req, wb_valid, ld_err;
    logic [31:0] mem_addr, wb_data;
    logic [4:0]  wb_rd;

    logic        t_ld_ready, t_mem_req, t_wb_valid, t_ld_err;
    logic [31:0] t_mem_addr, t_wb_data;
    logic [4:0]  t_wb_rd;

    int checkCount = 0;
    int errCount   = 0;

    always #5 clk = ~clk;

    load_unit dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_op(ld_op), .ld_addr(ld_addr), .ld_rd(ld_rd),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .ld_err(ld_err)
    );

    load_unit #(.TIMEOUT_CYC(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(t_ld_ready),
        .ld_op(ld_op), .ld_addr(ld_addr), .ld_rd(ld_rd),
        .mem_req(t_mem_req), .mem_addr(t_mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(t_wb_valid), .wb_ready(wb_ready), .wb_data(t_wb_data), .wb_rd(t_wb_rd),
        .ld_err(t_ld_err)
    );

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Hold reset for one cycle, optionally checking the reset values.
    task automatic doReset(input bit checkIt);
        @(negedge clk);
        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        mem_ack   = 1'b0;
        wb_ready  = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        if (checkIt) begin
            checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);
            checkOutput("rst_mem_req",  32'(mem_req),  32'd0);
            checkOutput("rst_mem_addr", mem_addr,      32'd0);
            checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
            checkOutput("rst_wb_data",  wb_data,       32'd0);
            checkOutput("rst_wb_rd",    32'(wb_rd),    32'd0);
            checkOutput("rst_ld_err",   32'(ld_err),   32'd0);
        end
        rst_n = 1'b1;
    endtask

    // One complete load on dut: ack in cycle ackCycle, wb_ready held low for holdCycles.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                                 input logic [31:0] rdata, input int ackCycle, input int holdCycles,
                                 input logic [31:0] expData, input string tag);
        logic [31:0] expAddr;
        expAddr = addr & 32'hFFFF_FFFC;
        @(negedge clk);
        ld_valid = 1'b1;
        ld_op    = op;
        ld_addr  = addr;
        ld_rd    = rd;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_addr  = 32'h0;
        for (int c = 1; c < ackCycle; c++) begin
            checkOutput({tag, "_req_wait"},   32'(mem_req),  32'd1);
            checkOutput({tag, "_addr_wait"},  mem_addr,      expAddr);
            checkOutput({tag, "_ready_wait"}, 32'(ld_ready), 32'd0);
            checkOutput({tag, "_wbv_wait"},   32'(wb_valid), 32'd0);
            @(negedge clk);
        end
        checkOutput({tag, "_req"},  32'(mem_req), 32'd1);
        checkOutput({tag, "_addr"}, mem_addr,     expAddr);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        for (int h = 0; h < holdCycles; h++) begin
            checkOutput({tag, "_wbv_hold"},   32'(wb_valid), 32'd1);
            checkOutput({tag, "_data_hold"},  wb_data,       expData);
            checkOutput({tag, "_rd_hold"},    32'(wb_rd),    32'(rd));
            checkOutput({tag, "_ready_hold"}, 32'(ld_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        checkOutput({tag, "_mem_req"},  32'(mem_req),  32'd0);
        checkOutput({tag, "_wb_data"},  wb_data,       expData);
        checkOutput({tag, "_wb_rd"},    32'(wb_rd),    32'(rd));
        checkOutput({tag, "_ld_err"},   32'(ld_err),   32'd0);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        checkOutput({tag, "_wbv_done"},   32'(wb_valid), 32'd0);
        checkOutput({tag, "_ready_done"}, 32'(ld_ready), 32'd1);
    endtask

`ifdef LOAD_UNIT_MISALIGN_TRAP_EN
    // A misaligned access must bypass memory and report an error on the next cycle.
    task automatic checkTrap(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd, input string tag);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_op    = op;
        ld_addr  = addr;
        ld_rd    = rd;
        @(negedge clk);
        ld_valid = 1'b0;
        checkOutput({tag, "_mem_req"},  32'(mem_req),  32'd0);
        checkOutput({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        checkOutput({tag, "_ld_err"},   32'(ld_err),   32'd1);
        checkOutput({tag, "_wb_data"},  wb_data,       32'd0);
        checkOutput({tag, "_wb_rd"},    32'(wb_rd),    32'(rd));
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        checkOutput({tag, "_ready_done"}, 32'(ld_ready), 32'd1);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        ld_op     = 3'b000;
        ld_addr   = 32'h0;
        ld_rd     = 5'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        wb_ready  = 1'b0;

        $display("[TB] reset values");
        doReset(1'b1);

        $display("[TB] extraction patterns");
        applyStimulus(LD_LB,  32'h1000_0003, 5'd5,  32'h80FF_1234, 1, 0, 32'hFFFF_FF80, "lb_b3");
        applyStimulus(LD_LBU, 32'h1000_0002, 5'd6,  32'h8001_7F00, 1, 0, 32'h0000_0001, "lbu_b2");
        applyStimulus(LD_LHU, 32'h1000_0002, 5'd7,  32'h8001_7F00, 1, 0, 32'h0000_8001, "lhu_h1");
        applyStimulus(LD_LH,  32'h1000_0002, 5'd8,  32'h8001_7F00, 2, 0, 32'hFFFF_8001, "lh_h1");
        applyStimulus(LD_LW,  32'h1000_0000, 5'd9,  32'h8001_7F00, 1, 0, 32'h8001_7F00, "lw_al");
        applyStimulus(LD_LB,  32'h1000_0001, 5'd10, 32'h8001_7F00, 1, 0, 32'h0000_007F, "lb_b1");
        applyStimulus(LD_LH,  32'h1000_0000, 5'd11, 32'h8001_7F00, 3, 0, 32'h0000_7F00, "lh_h0");
        applyStimulus(LD_LBU, 32'h1000_0003, 5'd12, 32'h8001_7F00, 1, 0, 32'h0000_0080, "lbu_b3");
        applyStimulus(3'b011, 32'h1000_0000, 5'd13, 32'h8001_7F00, 1, 0, 32'h8001_7F00, "op011_lw");
        applyStimulus(3'b111, 32'h1000_0000, 5'd14, 32'h1357_9BDF, 1, 0, 32'h1357_9BDF, "op111_lw");

        $display("[TB] delayed ack and WB backpressure");
        applyStimulus(LD_LHU, 32'h5000_0006, 5'd17, 32'hBEEF_0042, 6, 3, 32'h0000_BEEF, "long");

        doReset(1'b0);
`ifdef LOAD_UNIT_MISALIGN_TRAP_EN
        $display("[TB] misaligned accesses trap");
        checkTrap(LD_LW,  32'h3000_0001, 5'd7,  "trap_lw");
        checkTrap(LD_LHU, 32'h3000_0003, 5'd19, "trap_lhu");
`else
        $display("[TB] misaligned accesses pass through");
        applyStimulus(LD_LW, 32'h3000_0001, 5'd7,  32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D, "mis_lw");
        applyStimulus(LD_LH, 32'h3000_0003, 5'd19, 32'h8001_7F00, 1, 0, 32'hFFFF_8001, "mis_lh");
`endif

        $display("[TB] timeout without ack");
        doReset(1'b0);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_op    = LD_LW;
        ld_addr  = 32'h2000_0008;
        ld_rd    = 5'd3;
        @(negedge clk);
        ld_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checkOutput("to_req_wait", 32'(t_mem_req),  32'd1);
            checkOutput("to_wbv_wait", 32'(t_wb_valid), 32'd0);
            @(negedge clk);
        end
        checkOutput("to_mem_req",   32'(t_mem_req),  32'd0);
        checkOutput("to_wb_valid",  32'(t_wb_valid), 32'd1);
        checkOutput("to_ld_err",    32'(t_ld_err),   32'd1);
        checkOutput("to_wb_data",   t_wb_data,       32'd0);
        checkOutput("to_wb_rd",     32'(t_wb_rd),    32'd3);
        checkOutput("to_long_req",  32'(mem_req),    32'd1);

        $display("[TB] ack on last timeout cycle");
        doReset(1'b0);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_op    = LD_LW;
        ld_addr  = 32'h2000_000C;
        ld_rd    = 5'd4;
        @(negedge clk);
        ld_valid = 1'b0;
        for (int c = 1; c < 4; c++) @(negedge clk);
        checkOutput("ack4_req", 32'(t_mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        checkOutput("ack4_wb_valid", 32'(t_wb_valid), 32'd1);
        checkOutput("ack4_ld_err",   32'(t_ld_err),   32'd0);
        checkOutput("ack4_wb_data",  t_wb_data,       32'h1234_5678);

        $display("[TB] reset during REQ");
        doReset(1'b0);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_op    = LD_LW;
        ld_addr  = 32'h4000_0010;
        ld_rd    = 5'd9;
        @(negedge clk);
        ld_valid = 1'b0;
        checkOutput("mid_req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_mem_req",  32'(mem_req),  32'd0);
        checkOutput("mid_mem_addr", mem_addr,      32'd0);
        checkOutput("mid_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("mid_wb_rd",    32'(wb_rd),    32'd0);
        checkOutput("mid_wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5_5A5A;
        @(negedge clk);
        mem_ack   = 1'b0;
        checkOutput("late_ack_wbv",   32'(wb_valid), 32'd0);
        checkOutput("late_ack_req",   32'(mem_req),  32'd0);
        checkOutput("late_ack_ready", 32'(ld_ready), 32'd1);
        @(negedge clk);
        checkOutput("late_ack_wbv2",  32'(wb_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
